// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode/funct/ALU encodings plus the pipelined control-unit
// state and registered control bundle.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00, J     = 6'h02, JAL   = 6'h03, BEQ   = 6'h04,
    BNE   = 6'h05, ADDI  = 6'h08, ADDIU = 6'h09, SLTI  = 6'h0A,
    SLTIU = 6'h0B, ANDI  = 6'h0C, ORI   = 6'h0D, XORI  = 6'h0E,
    LUI   = 6'h0F, LW    = 6'h23, SW    = 6'h2B, HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'd0,  SRL  = 6'd2,  JR  = 6'd8,  ADD = 6'd32, ADDU = 6'd33,
    SUB  = 6'd34, SUBU = 6'd35, AND = 6'd36, OR  = 6'd37, XOR  = 6'd38,
    NOR  = 6'd39, SLT  = 6'd42, SLTU = 6'd43
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  // ALUSrc: second ALU operand
  localparam logic [1:0] SRC_REG = 2'd0, SRC_IMM = 2'd1, SRC_SHAMT = 2'd2;
  // RegSel: write-back source
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_LUI = 2'd3;
  // PCSrc: next-PC source
  localparam logic [1:0] PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_JR = 2'd3;

  localparam regbits_t REG_RA = 5'd31;

  typedef enum logic [1:0] {RUN, BUBBLE, HALTED} cu_state_t;

  typedef struct packed {
    logic [1:0] alusrc;
    aluop_t     aluop;
    logic [1:0] regsel;
    regbits_t   regdst;
    logic [1:0] pcsrc;
    logic       regwr;
    logic       extop;
    logic       dren;
    logic       dwen;
    logic       halt;
  } cu_ctrl_t;

  function automatic regbits_t instr_rs(word_t w);
    return w[25:21];
  endfunction

  function automatic regbits_t instr_rt(word_t w);
    return w[20:16];
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decode into the control bundle; same table as the
// legacy single-cycle control unit.
module cu_decode
  import cpu_types_pkg::*;
(
  input  word_t    instr,
  output cu_ctrl_t ctrl
);

  logic [5:0] op;
  logic [5:0] funct;
  regbits_t   rt;
  regbits_t   rd;
  logic       unused_fields;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    ctrl = '0;
    case (op)
      RTYPE: begin
        ctrl.regdst = rd;
        ctrl.regwr  = 1'b1;
        case (funct)
          SLL:        begin ctrl.aluop = ALU_SLL; ctrl.alusrc = SRC_SHAMT; end
          SRL:        begin ctrl.aluop = ALU_SRL; ctrl.alusrc = SRC_SHAMT; end
          JR:         begin ctrl.pcsrc = PC_JR;   ctrl.regwr  = 1'b0;      end
          ADD, ADDU:  ctrl.aluop = ALU_ADD;
          SUB, SUBU:  ctrl.aluop = ALU_SUB;
          AND:        ctrl.aluop = ALU_AND;
          OR:         ctrl.aluop = ALU_OR;
          XOR:        ctrl.aluop = ALU_XOR;
          NOR:        ctrl.aluop = ALU_NOR;
          SLT:        ctrl.aluop = ALU_SLT;
          SLTU:       ctrl.aluop = ALU_SLTU;
          default:    ctrl = '0;
        endcase
      end
      J:   ctrl.pcsrc = PC_JMP;
      JAL: begin
        ctrl.pcsrc  = PC_JMP;
        ctrl.regsel = WB_PC4;
        ctrl.regdst = REG_RA;
        ctrl.regwr  = 1'b1;
      end
      BEQ, BNE: begin
        ctrl.aluop = ALU_SUB;
        ctrl.extop = 1'b1;
        ctrl.pcsrc = PC_BR;
      end
      ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI: begin
        ctrl.alusrc = SRC_IMM;
        ctrl.regdst = rt;
        ctrl.regwr  = 1'b1;
        case (op)
          ADDI, ADDIU: begin ctrl.aluop = ALU_ADD;  ctrl.extop = 1'b1; end
          SLTI:        begin ctrl.aluop = ALU_SLT;  ctrl.extop = 1'b1; end
          SLTIU:       begin ctrl.aluop = ALU_SLTU; ctrl.extop = 1'b1; end
          ANDI:        ctrl.aluop = ALU_AND;
          ORI:         ctrl.aluop = ALU_OR;
          default:     ctrl.aluop = ALU_XOR;
        endcase
      end
      LUI: begin
        ctrl.alusrc = SRC_IMM;
        ctrl.regsel = WB_LUI;
        ctrl.regdst = rt;
        ctrl.regwr  = 1'b1;
      end
      LW: begin
        ctrl.alusrc = SRC_IMM;
        ctrl.aluop  = ALU_ADD;
        ctrl.extop  = 1'b1;
        ctrl.dren   = 1'b1;
        ctrl.regsel = WB_MEM;
        ctrl.regdst = rt;
        ctrl.regwr  = 1'b1;
      end
      SW: begin
        ctrl.alusrc = SRC_IMM;
        ctrl.aluop  = ALU_ADD;
        ctrl.extop  = 1'b1;
        ctrl.dwen   = 1'b1;
      end
      HALT:    ctrl.halt = 1'b1;
      default: ctrl = '0;
    endcase
    // $0 is hardwired, so a write to it is never a real write
    if (ctrl.regdst == '0) ctrl.regwr = 1'b0;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Registered, handshaked control unit at ID/EX: load-use interlock, sticky HALT
// and flush. Define CU_PERF_EN to add the consumed-bundle and stall counters.
module pipe_control_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W           = 32,
  parameter int unsigned REG_W            = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [1:0]        ALUSrc_o,
  output aluop_t            ALUOp_o,
  output logic [1:0]        RegSel_o,
  output logic [REG_W-1:0]  RegDst_o,
  output logic [1:0]        PCSrc_o,
  output logic              RegWr_o,
  output logic              ExtOp_o,
  output logic              dREN_o,
  output logic              dWEN_o,
  output logic              halt_o,
  output logic              stalled_o
`ifdef CU_PERF_EN
  ,
  output logic [31:0]       dec_count_o,
  output logic [31:0]       stall_count_o
`endif
);

  localparam logic [1:0] BUBBLE_LOAD = 2'(LOAD_USE_BUBBLES - 1);

  cu_state_t  state, state_n;
  logic [1:0] cnt, cnt_n;
  cu_ctrl_t   dec, ctrl_q;
  logic       out_valid_q;
  logic       ld_vld;
  regbits_t   ld_dst;
  logic       hazard;
  logic       accept;

  cu_decode u_decode (
    .instr (instr_i),
    .ctrl  (dec)
  );

  // rt is compared even for instructions that do not read it
  assign hazard = ld_vld && (instr_rs(instr_i) == ld_dst || instr_rt(instr_i) == ld_dst);

  assign instr_ready_o = (state == RUN) && !flush_i && !hazard &&
                         (!out_valid_q || out_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      RUN: begin
        if (!flush_i) begin
          if (instr_valid_i && hazard) begin
            state_n = BUBBLE;
            cnt_n   = BUBBLE_LOAD;
          end else if (accept && dec.halt) begin
            state_n = HALTED;
          end
        end
      end
      BUBBLE: begin
        if (flush_i || cnt == '0) state_n = RUN;
        else                      cnt_n   = cnt - 2'd1;
      end
      HALTED: begin
        // only an unconsumed HALT can be squashed back into RUN
        if (flush_i && out_valid_q && ctrl_q.halt) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ld_vld <= 1'b0;
      ld_dst <= '0;
    end else if (flush_i) begin
      ld_vld <= 1'b0;
    end else if (accept) begin
      ld_vld <= dec.dren && (dec.regdst != '0);
      ld_dst <= dec.regdst;
    end else if (state == BUBBLE && cnt == '0) begin
      ld_vld <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign ALUSrc_o    = ctrl_q.alusrc;
  assign ALUOp_o     = ctrl_q.aluop;
  assign RegSel_o    = ctrl_q.regsel;
  assign RegDst_o    = ctrl_q.regdst;
  assign PCSrc_o     = ctrl_q.pcsrc;
  assign RegWr_o     = ctrl_q.regwr;
  assign ExtOp_o     = ctrl_q.extop;
  assign dREN_o      = ctrl_q.dren;
  assign dWEN_o      = ctrl_q.dwen;
  assign halt_o      = ctrl_q.halt;
  assign stalled_o   = (state == BUBBLE);

`ifdef CU_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dec_count_o   <= '0;
      stall_count_o <= '0;
    end else begin
      if (out_valid_q && out_ready_i) dec_count_o   <= dec_count_o + 32'd1;
      if (state == BUBBLE)            stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: directed scenarios then random traffic
// against a mnemonic-level reference model.
module tb_pipe_control_unit;
  import cpu_types_pkg::*;

  localparam int unsigned LUB = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  word_t       instr_i = '0;
  logic        instr_valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
  logic        instr_ready_o, out_valid_o;
  logic [1:0]  ALUSrc_o, RegSel_o, PCSrc_o;
  aluop_t      ALUOp_o;
  regbits_t    RegDst_o;
  logic        RegWr_o, ExtOp_o, dREN_o, dWEN_o, halt_o, stalled_o;
`ifdef CU_PERF_EN
  logic [31:0] dec_count_o, stall_count_o;
`endif

  always #5 CLK = ~CLK;

  pipe_control_unit #(.WORD_W(32), .REG_W(5), .LOAD_USE_BUBBLES(LUB)) dut (
    .CLK(CLK), .nRST(nRST), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
    .RegSel_o(RegSel_o), .RegDst_o(RegDst_o), .PCSrc_o(PCSrc_o), .RegWr_o(RegWr_o),
    .ExtOp_o(ExtOp_o), .dREN_o(dREN_o), .dWEN_o(dWEN_o), .halt_o(halt_o),
    .stalled_o(stalled_o)
`ifdef CU_PERF_EN
    , .dec_count_o(dec_count_o), .stall_count_o(stall_count_o)
`endif
  );

  typedef enum {
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_JR, M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI,
    M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL, M_HALT, M_BAD
  } mn_t;

  typedef struct {
    word_t    w;
    regbits_t rs;
    regbits_t rt;
    cu_ctrl_t exp;
  } tb_ins_t;

  int          total = 0;
  int          bad   = 0;
  cu_ctrl_t    sb[$];
  cu_ctrl_t    obs;

  bit          m_out, m_out_halt, m_halted, m_ld_vld;
  regbits_t    m_ld_dst;
  int          m_stall;
  logic [31:0] m_dec, m_stl;

  assign obs = {ALUSrc_o, ALUOp_o, RegSel_o, RegDst_o, PCSrc_o,
                RegWr_o, ExtOp_o, dREN_o, dWEN_o, halt_o};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected bundle straight from the mnemonic and its register operands.
  function automatic tb_ins_t mk(mn_t m, regbits_t rs, regbits_t rt, regbits_t rd,
                                 logic [15:0] imm);
    tb_ins_t    t;
    cu_ctrl_t   c = '0;
    logic [5:0] fn = '0;
    logic [5:0] op = 6'h00;
    bit         r  = 1'b0;
    bit         wrt = 1'b0;
    case (m)
      M_ADD:   begin r = 1; fn = ADD;  c.aluop = ALU_ADD;  end
      M_ADDU:  begin r = 1; fn = ADDU; c.aluop = ALU_ADD;  end
      M_SUB:   begin r = 1; fn = SUB;  c.aluop = ALU_SUB;  end
      M_SUBU:  begin r = 1; fn = SUBU; c.aluop = ALU_SUB;  end
      M_AND:   begin r = 1; fn = AND;  c.aluop = ALU_AND;  end
      M_OR:    begin r = 1; fn = OR;   c.aluop = ALU_OR;   end
      M_XOR:   begin r = 1; fn = XOR;  c.aluop = ALU_XOR;  end
      M_NOR:   begin r = 1; fn = NOR;  c.aluop = ALU_NOR;  end
      M_SLT:   begin r = 1; fn = SLT;  c.aluop = ALU_SLT;  end
      M_SLTU:  begin r = 1; fn = SLTU; c.aluop = ALU_SLTU; end
      M_SLL:   begin r = 1; fn = SLL;  c.aluop = ALU_SLL; c.alusrc = SRC_SHAMT; end
      M_SRL:   begin r = 1; fn = SRL;  c.aluop = ALU_SRL; c.alusrc = SRC_SHAMT; end
      M_JR:    begin r = 1; fn = JR;   c.pcsrc = PC_JR; end
      M_ADDI:  begin op = ADDI;  wrt = 1; c.aluop = ALU_ADD;  c.extop = 1; end
      M_ADDIU: begin op = ADDIU; wrt = 1; c.aluop = ALU_ADD;  c.extop = 1; end
      M_SLTI:  begin op = SLTI;  wrt = 1; c.aluop = ALU_SLT;  c.extop = 1; end
      M_SLTIU: begin op = SLTIU; wrt = 1; c.aluop = ALU_SLTU; c.extop = 1; end
      M_ANDI:  begin op = ANDI;  wrt = 1; c.aluop = ALU_AND; end
      M_ORI:   begin op = ORI;   wrt = 1; c.aluop = ALU_OR;  end
      M_XORI:  begin op = XORI;  wrt = 1; c.aluop = ALU_XOR; end
      M_LUI:   begin op = LUI;   wrt = 1; c.regsel = WB_LUI; end
      M_LW:    begin op = LW;    wrt = 1; c.aluop = ALU_ADD; c.extop = 1;
                     c.dren = 1; c.regsel = WB_MEM; end
      M_SW:    begin op = SW; c.alusrc = SRC_IMM; c.aluop = ALU_ADD; c.extop = 1;
                     c.dwen = 1; end
      M_BEQ:   begin op = BEQ; c.aluop = ALU_SUB; c.extop = 1; c.pcsrc = PC_BR; end
      M_BNE:   begin op = BNE; c.aluop = ALU_SUB; c.extop = 1; c.pcsrc = PC_BR; end
      M_J:     begin op = J;   c.pcsrc = PC_JMP; end
      M_JAL:   begin op = JAL; c.pcsrc = PC_JMP; c.regsel = WB_PC4;
                     c.regdst = 5'd31; c.regwr = 1; end
      M_HALT:  begin op = HALT; c.halt = 1; end
      default: op = 6'h3E;
    endcase
    if (r) begin
      c.regdst = rd;
      c.regwr  = (m != M_JR);
      t.w = {6'h00, rs, rt, rd, imm[10:6], fn};
    end else begin
      if (wrt) begin
        c.alusrc = SRC_IMM; c.regdst = rt; c.regwr = 1;
      end
      t.w = {op, rs, rt, imm};
    end
    if (c.regdst == 5'd0) c.regwr = 0;
    t.rs  = t.w[25:21];
    t.rt  = t.w[20:16];
    t.exp = c;
    return t;
  endfunction

  // Bundle checker: every presented bundle must match the oldest outstanding one.
  always @(negedge CLK) begin
    if (nRST) begin
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow at %0t: got bundle %0h expected none", $time, obs);
        end else begin
          chk("bundle", 32'(obs), 32'(sb[0]));
          if (out_ready_i || flush_i) void'(sb.pop_front());
        end
      end else begin
        chk("nop_bundle", 32'(obs), 32'd0);
      end
    end
  end

  task automatic model_clear();
    m_out = 0; m_out_halt = 0; m_halted = 0; m_ld_vld = 0; m_ld_dst = '0;
    m_stall = 0; m_dec = '0; m_stl = '0;
    sb.delete();
  endtask

  task automatic rst();
    nRST = 1'b0; instr_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    model_clear();
    #1;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_bundle", 32'(obs), 32'd0);
    chk("rst_stalled", 32'(stalled_o), 32'd0);
    chk("rst_ready", 32'(instr_ready_o), 32'd1);
`ifdef CU_PERF_EN
    chk("rst_dec_count", dec_count_o, 32'd0);
    chk("rst_stall_count", stall_count_o, 32'd0);
`endif
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  // One clock: drive, check against the model at mid-cycle, advance the model.
  task automatic cyc(input bit v, input tb_ins_t ins, input bit fl, input bit rdy,
                     output bit acc);
    bit hz, run, exp_rdy;
    int pre_stall;
    instr_valid_i = v; instr_i = ins.w; flush_i = fl; out_ready_i = rdy;
    @(negedge CLK);
    hz      = m_ld_vld && (ins.rs == m_ld_dst || ins.rt == m_ld_dst);
    run     = !m_halted && m_stall == 0;
    exp_rdy = run && !fl && !hz && (!m_out || rdy);
    chk("instr_ready", 32'(instr_ready_o), 32'(exp_rdy));
    chk("stalled", 32'(stalled_o), 32'(m_stall > 0));
    chk("out_valid", 32'(out_valid_o), 32'(m_out));
    chk("halt", 32'(halt_o), 32'(m_out && m_out_halt));
`ifdef CU_PERF_EN
    chk("dec_count", dec_count_o, m_dec);
    chk("stall_count", stall_count_o, m_stl);
`endif
    acc = v && exp_rdy;
    pre_stall = m_stall;
    if (m_out && rdy) m_dec++;
    if (pre_stall > 0) m_stl++;
    if (fl) begin
      if (m_halted && m_out && m_out_halt) m_halted = 0;
      m_out = 0; m_out_halt = 0; m_ld_vld = 0; m_stall = 0;
    end else begin
      if (acc) begin
        m_out = 1; m_out_halt = ins.exp.halt;
        m_ld_vld = ins.exp.dren && ins.exp.regdst != 5'd0;
        m_ld_dst = ins.exp.regdst;
        if (ins.exp.halt) m_halted = 1;
        sb.push_back(ins.exp);
      end else if (rdy) begin
        m_out = 0; m_out_halt = 0;
      end
      if (pre_stall > 0) begin
        m_stall--;
        if (m_stall == 0) m_ld_vld = 0;
      end else if (run && v && hz) begin
        m_stall = LUB;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic issue(input tb_ins_t ins);
    bit a = 0;
    int n = 0;
    while (!a && n < 20) begin
      cyc(1, ins, 0, 1, a);
      n++;
    end
    if (!a) begin
      total++; bad++;
      $display("FAIL issue_timeout at %0t: got no accept expected accept within 20 cycles", $time);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, mk(M_BAD, 5'd0, 5'd0, 5'd0, 16'd0), 0, rdy, a);
  endtask

  initial begin
    bit a;
    tb_ins_t t;
    rst();

    issue(mk(M_ADD, 5'd1, 5'd2, 5'd3, 16'd0));
    idle(1, 1);

    issue(mk(M_LW, 5'd1, 5'd2, 5'd0, 16'd0));
    issue(mk(M_ADD, 5'd2, 5'd5, 5'd4, 16'd0));
    idle(2, 1);

    issue(mk(M_LW, 5'd1, 5'd2, 5'd0, 16'd0));
    issue(mk(M_ADD, 5'd6, 5'd5, 5'd4, 16'd0));
    idle(1, 1);

    issue(mk(M_SW, 5'd1, 5'd7, 5'd0, 16'd4));
    for (int i = 0; i < 3; i++) cyc(1, mk(M_OR, 5'd8, 5'd9, 5'd10, 16'd0), 0, 0, a);
    issue(mk(M_OR, 5'd8, 5'd9, 5'd10, 16'd0));
    idle(1, 1);

    issue(mk(M_HALT, 5'd0, 5'd0, 5'd0, 16'd0));
    cyc(0, mk(M_BAD, 5'd0, 5'd0, 5'd0, 16'd0), 1, 0, a);
    issue(mk(M_ADDI, 5'd1, 5'd0, 5'd0, 16'h0010));
    issue(mk(M_HALT, 5'd0, 5'd0, 5'd0, 16'd0));
    idle(2, 1);
    cyc(0, mk(M_BAD, 5'd0, 5'd0, 5'd0, 16'd0), 1, 1, a);
    for (int i = 0; i < 3; i++) cyc(1, mk(M_JAL, 5'd3, 5'd4, 5'd0, 16'd0), 0, 1, a);
    rst();

    issue(mk(M_LW, 5'd1, 5'd2, 5'd0, 16'd8));
    cyc(1, mk(M_ADD, 5'd2, 5'd5, 5'd4, 16'd0), 1, 1, a);
    issue(mk(M_ADD, 5'd2, 5'd5, 5'd4, 16'd0));
    idle(1, 1);

    for (int i = 0; i < 1500; i++) begin
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        rst();
      end else begin
        mn_t m;
        int  r = $urandom_range(0, 99);
        if (r < 2)       m = M_HALT;
        else if (r < 4)  m = M_BAD;
        else if (r < 30) m = M_LW;
        else             m = mn_t'($urandom_range(0, int'(M_JAL)));
        t = mk(m, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 16'($urandom));
        cyc($urandom_range(0, 3) != 0, t, $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) != 0, a);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
